ulight_fifo_pll_rst_seq: RTL and testbench

Reset and lock sequencer downstream of the uLight FIFO PLL. Drives the PLL reset, qualifies the asynchronous `locked` output with a synchronizer and a stability window, and produces the system reset consumed by the SpaceWire/FIFO logic clocked from the 400 MHz output. On lock loss it re-resets the PLL and counts relock events. It also flags lock-acquisition timeouts. Runs entirely in the 100 MHz reference-clock domain.

---
 rtl/ulight_fifo_pll_rst_pkg.sv | 23 ++
 rtl/ulight_fifo_sync_bit.sv | 24 ++
 rtl/ulight_fifo_pll_rst_seq.sv | 109 ++++++++++
 tb/tb_ulight_fifo_pll_rst_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ulight_fifo_pll_rst_pkg.sv
// Shared types and helpers for the uLight FIFO PLL reset/lock sequencer.
//   state_t   : sequencer states
//   cnt_width : width of the shared cycle counter, derived from the
//               largest of the three cycle-count parameters
package ulight_fifo_pll_rst_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Never returns less than 1 so the counter always has at least one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ulight_fifo_sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous clear to 0.
//   clk : destination clock
//   rst : asynchronous active-high clear
//   d   : asynchronous input
//   q   : synchronized output (last flop)
module ulight_fifo_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_p <= '0;
    else     sync_p <= {sync_p[STAGES-2:0], d};
  end

  assign q = sync_p[STAGES-1];

endmodule

// File: rtl/ulight_fifo_pll_rst_seq.sv
// Reset and lock sequencer for the uLight FIFO PLL, refclk domain only.
// Holds the PLL in reset, waits for a synchronized and stable lock, then
// releases the downstream system reset. Lock loss re-resets the PLL and is
// counted; lock-acquisition timeouts are flagged stickily.
//   refclk       : 100 MHz reference clock
//   rst          : asynchronous active-high reset
//   locked       : PLL lock, asynchronous
//   pll_rst      : PLL reset request
//   sys_rst      : downstream system reset (high except in RUN)
//   ready        : high in RUN
//   lock_lost    : one-cycle pulse on RUN -> PLL_RST
//   timeout_err  : sticky lock-acquisition timeout flag
//   relock_count : saturating count of lock losses
module ulight_fifo_pll_rst_seq
  import ulight_fifo_pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 100000
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       lock_lost,
  output logic       timeout_err,
  output logic [7:0] relock_count
);

  localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] PLL_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  logic             locked_s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             timeout_set;
  logic             loss;

  ulight_fifo_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  always_comb begin
    state_nxt   = state;
    timeout_set = 1'b0;
    loss        = 1'b0;
    case (state)
      PLL_RST: begin
        if (cnt == PLL_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (locked_s) begin
          state_nxt = STABLE;
        end else if (cnt == TMO_LAST) begin
          state_nxt   = PLL_RST;
          timeout_set = 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s)             state_nxt = WAIT_LOCK;
        else if (cnt == STB_LAST)  state_nxt = RUN;
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt = PLL_RST;
          loss      = 1'b1;
        end
      end
      default: state_nxt = PLL_RST;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same
  // edge as the state register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state        <= PLL_RST;
      cnt          <= '0;
      pll_rst      <= 1'b1;
      sys_rst      <= 1'b1;
      ready        <= 1'b0;
      lock_lost    <= 1'b0;
      timeout_err  <= 1'b0;
      relock_count <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= (state_nxt != state) ? '0 : cnt + 1'b1;
      pll_rst   <= (state_nxt == PLL_RST);
      sys_rst   <= (state_nxt != RUN);
      ready     <= (state_nxt == RUN);
      lock_lost <= loss;
      if (timeout_set) timeout_err <= 1'b1;
      if (loss && relock_count != 8'hFF) relock_count <= relock_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_ulight_fifo_pll_rst_seq.sv
// Bench for ulight_fifo_pll_rst_seq (PLL_RST=4, STABLE=8, TIMEOUT=32, SYNC=2).
// Stimulus schedules expected output vectors against an edge counter; a
// monitor compares them on the falling edge of the cycle they are due.
module tb_ulight_fifo_pll_rst_seq;

  logic       refclk;
  logic       rst;
  logic       locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       lock_lost;
  logic       timeout_err;
  logic [7:0] relock_count;

  ulight_fifo_pll_rst_seq #(
    .SYNC_STAGES         (2),
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .locked       (locked),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .lock_lost    (lock_lost),
    .timeout_err  (timeout_err),
    .relock_count (relock_count)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [12:0] vec;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [12:0] dut_vec;

  assign dut_vec = {pll_rst, sys_rst, ready, lock_lost, timeout_err, relock_count};

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  always @(posedge refclk) cyc <= cyc + 1;

  // {pll_rst, sys_rst, ready, lock_lost, timeout_err, relock_count}
  function automatic logic [12:0] vec(input logic p, input logic s, input logic r,
                                      input logic ll, input logic te, input int rc);
    return {p, s, r, ll, te, 8'(rc)};
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got pll/sys/rdy/ll/te/cnt=%b/%b/%b/%b/%b/%0d want %b/%b/%b/%b/%b/%0d",
               name, cyc, act[12], act[11], act[10], act[9], act[8], act[7:0],
               exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic push(input int at, input string name, input logic [12:0] v);
    exp_t e;
    e.cyc  = at;
    e.name = name;
    e.vec  = v;
    sb.push_back(e);
  endtask

  // Returns just after the falling edge once `n` rising edges have occurred.
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge refclk);
    #1;
  endtask

  // Monitor: compare every entry due this cycle; stale entries are misses.
  always @(negedge refclk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check(sb[i].name, dut_vec, sb[i].vec);
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s: due at edge %0d, not checked (now %0d)", sb[i].name, sb[i].cyc, cyc);
        sb.delete(i);
      end
    end
  end

  initial begin
    int b, c, k, k2, rc;
    rst    = 1'b1;
    locked = 1'b0;
    repeat (3) @(negedge refclk);
    #1;
    check("reset_values", dut_vec, vec(1, 1, 0, 0, 0, 0));

    // Lock never asserts: 4 edges of pll_rst, 32 in WAIT_LOCK, timeout, retry.
    b   = cyc;
    rst = 1'b0;
    push(b + 1,  "s1_pll_first",   vec(1, 1, 0, 0, 0, 0));
    push(b + 3,  "s1_pll_hold",    vec(1, 1, 0, 0, 0, 0));
    push(b + 4,  "s1_wait",        vec(0, 1, 0, 0, 0, 0));
    push(b + 35, "s1_wait_last",   vec(0, 1, 0, 0, 0, 0));
    push(b + 36, "s1_timeout",     vec(1, 1, 0, 0, 1, 0));
    push(b + 39, "s1_retry_hold",  vec(1, 1, 0, 0, 1, 0));
    push(b + 40, "s1_retry_wait",  vec(0, 1, 0, 0, 1, 0));
    wait_cyc(b + 42);

    // Normal acquisition after a fresh reset (also clears timeout_err).
    rst = 1'b1;
    #2;
    check("s2_async_clear", dut_vec, vec(1, 1, 0, 0, 0, 0));
    wait_cyc(cyc + 2);
    b   = cyc;
    rst = 1'b0;
    wait_cyc(b + 6);
    c      = cyc;
    locked = 1'b1;
    k      = c + 1;
    push(k + 9,  "s2_stable_hold", vec(0, 1, 0, 0, 0, 0));
    push(k + 10, "s2_run",         vec(0, 0, 1, 0, 0, 0));
    wait_cyc(k + 12);

    // Lock loss in RUN.
    c      = cyc;
    locked = 1'b0;
    k      = c + 1;
    push(k + 1, "s4_still_run",  vec(0, 0, 1, 0, 0, 0));
    push(k + 2, "s4_lost",       vec(1, 1, 0, 1, 0, 1));
    push(k + 3, "s4_pulse_end",  vec(1, 1, 0, 0, 0, 1));
    push(k + 5, "s4_pll_hold",   vec(1, 1, 0, 0, 0, 1));
    push(k + 6, "s4_wait",       vec(0, 1, 0, 0, 0, 1));
    wait_cyc(k + 8);

    // Glitch during STABLE: 3-cycle drop restarts the window.
    c      = cyc;
    locked = 1'b1;
    k      = c + 1;
    wait_cyc(k + 4);
    locked = 1'b0;
    wait_cyc(k + 7);
    locked = 1'b1;
    k2     = k + 8;
    push(k + 10,  "s3_no_early_run", vec(0, 1, 0, 0, 0, 1));
    push(k2 + 9,  "s3_stable_hold",  vec(0, 1, 0, 0, 0, 1));
    push(k2 + 10, "s3_run",          vec(0, 0, 1, 0, 0, 1));
    wait_cyc(k2 + 12);

    // Asynchronous reset while in STABLE.
    c      = cyc;
    locked = 1'b0;
    k      = c + 1;
    wait_cyc(k + 5);
    locked = 1'b1;
    push(k + 11, "s5_in_stable", vec(0, 1, 0, 0, 0, 2));
    wait_cyc(k + 11);
    @(posedge refclk);
    #3;
    rst = 1'b1;
    #1;
    check("s5_async_reset", dut_vec, vec(1, 1, 0, 0, 0, 0));

    // Counter saturation over 256 lock losses.
    wait_cyc(cyc + 2);
    b   = cyc;
    rst = 1'b0;
    push(b + 13, "s6_run0", vec(0, 0, 1, 0, 0, 0));
    wait_cyc(b + 14);
    for (int i = 0; i < 256; i++) begin
      c      = cyc;
      locked = 1'b0;
      rc     = (i + 1 > 255) ? 255 : i + 1;
      push(c + 3, "s6_lost",      vec(1, 1, 0, 1, 0, rc));
      push(c + 4, "s6_pulse_end", vec(1, 1, 0, 0, 0, rc));
      wait_cyc(c + 3);
      locked = 1'b1;
      push(c + 16, "s6_run", vec(0, 0, 1, 0, 0, rc));
      wait_cyc(c + 17);
    end

    wait_cyc(cyc + 3);
    while (sb.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: never checked (due edge %0d)", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
